// File: rtl/kbd_port68_pkg.sv
// Shared constants for the PS/2 keyboard port on the 68000 bus.
package kbd_port68_pkg;

  // Register offsets as seen on cpu_a[1]
  localparam logic REG_DATA   = 1'b0;
  localparam logic REG_STATUS = 1'b1;

  // STATUS bit positions
  localparam int ST_OVF   = 15;
  localparam int ST_FLUSH = 14;
  localparam int ST_IRQEN = 8;

  // DATA bit positions
  localparam int D_VALID   = 15;
  localparam int D_PRESSED = 9;
  localparam int D_EXT     = 8;

  // Queued entry: {pressed, extended, code[7:0]}
  localparam int KEY_W = 10;

endpackage

// File: rtl/kbd_port68_fifo.sv
// Synchronous key-event FIFO. Flush beats push/pop; pushes to a full
// FIFO and pops from an empty one are ignored.
module kbd_fifo #(
  parameter int DEPTH = 16,
  parameter int KEY_W = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [KEY_W-1:0]           wdata,
  output logic [KEY_W-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [KEY_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/kbd_port68.sv
// PS/2 keyboard port: toggle-strobe event capture, event FIFO, DATA/STATUS
// registers committed at the end of each CPU bus cycle, and a level irq.
module kbd_port68
  import kbd_port68_pkg::*;
#(
  parameter int DEPTH            = 16,
  parameter bit C_RELEASE_EVENTS = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic        cs,
  input  logic        as_n,
  input  logic        rw,
  input  logic        addr,
  input  logic        uds_n,
  input  logic        lds_n,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic          prev_tog_q, armed_q;
  logic          pend_q, rw_q, addr_q, uds_n_q;
  logic          wr_ovf_clr_q, wr_flush_q, wr_irqen_q;
  logic          ovf_q, ovf_d;
  logic          irq_en_q, irq_en_d;
  logic          irq_q;

  logic          tog_evt, accept, access_open, commit;
  logic          st_wr_hi, data_rd;
  logic          fifo_push, fifo_pop, fifo_flush;
  logic          fifo_full, fifo_empty;
  logic [KEY_W-1:0] fifo_rdata;
  logic [CW-1:0] fifo_count, count_next;

  // Bits of the bus this port does not decode
  logic unused_bits;
  assign unused_bits = &{1'b0, lds_n, din[13:9], din[7:0]};

  assign tog_evt     = armed_q && (ps2_key[10] != prev_tog_q);
  assign accept      = tog_evt && (C_RELEASE_EVENTS || ps2_key[D_PRESSED]);
  assign access_open = cs && !as_n;
  assign commit      = pend_q && as_n;
  assign st_wr_hi    = commit && !rw_q && (addr_q == REG_STATUS) && !uds_n_q;
  assign data_rd     = commit && rw_q && (addr_q == REG_DATA);

  assign fifo_flush  = st_wr_hi && wr_flush_q;
  assign fifo_push   = accept && !fifo_full;
  assign fifo_pop    = data_rd && !fifo_empty;

  kbd_fifo #(
    .DEPTH (DEPTH),
    .KEY_W (KEY_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .wdata (ps2_key[KEY_W-1:0]),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next occupancy and status bits; overflow set beats clear, flush beats set
  always_comb begin
    if (fifo_flush)
      count_next = '0;
    else
      count_next = fifo_count + {{AW{1'b0}}, fifo_push} - {{AW{1'b0}}, fifo_pop};

    irq_en_d = irq_en_q;
    ovf_d    = ovf_q;
    if (st_wr_hi) begin
      irq_en_d = wr_irqen_q;
      if (wr_ovf_clr_q) ovf_d = 1'b0;
    end
    if (accept && fifo_full && !fifo_flush) ovf_d = 1'b1;
  end

  // Toggle edge tracking; the first cycle out of reset only arms
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_tog_q <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      prev_tog_q <= ps2_key[10];
      armed_q    <= 1'b1;
    end
  end

  // Latch the open bus cycle; it commits once as_n goes high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q       <= 1'b0;
      rw_q         <= 1'b1;
      addr_q       <= REG_DATA;
      uds_n_q      <= 1'b1;
      wr_ovf_clr_q <= 1'b0;
      wr_flush_q   <= 1'b0;
      wr_irqen_q   <= 1'b0;
    end else if (access_open) begin
      pend_q       <= 1'b1;
      rw_q         <= rw;
      addr_q       <= addr;
      uds_n_q      <= uds_n;
      wr_ovf_clr_q <= din[ST_OVF];
      wr_flush_q   <= din[ST_FLUSH];
      wr_irqen_q   <= din[ST_IRQEN];
    end else if (commit) begin
      pend_q       <= 1'b0;
    end
  end

  // Status registers and irq, which tracks the count change in the same clk
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q    <= 1'b0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      ovf_q    <= ovf_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_en_d && (count_next != '0);
    end
  end

  assign irq = irq_q;

  // Read mux follows the live address so dout is stable through the cycle
  always_comb begin
    dout = 16'h0000;
    if (addr == REG_DATA) begin
      if (!fifo_empty) begin
        dout[D_VALID]     = 1'b1;
        dout[KEY_W-1:0]   = fifo_rdata;
      end
    end else begin
      dout[ST_OVF]   = ovf_q;
      dout[ST_IRQEN] = irq_en_q;
      dout[6:0]      = 7'(fifo_count);
    end
  end

endmodule

// File: tb/tb_kbd_port68.sv
// Self-checking bench for kbd_port68: queue-based reference model checked
// every cycle, plus hand-computed register values at key points.
module tb_kbd_port68;
  import kbd_port68_pkg::*;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic        cs, as_n, rw, addr, uds_n, lds_n;
  logic [15:0] din;
  logic [15:0] dout, dout_nr;
  logic        irq, irq_nr;

  always #5 clk = ~clk;

  kbd_port68 #(.DEPTH(DEPTH), .C_RELEASE_EVENTS(1'b1)) dut (
    .clk(clk), .reset(reset), .ps2_key(ps2_key), .cs(cs), .as_n(as_n),
    .rw(rw), .addr(addr), .uds_n(uds_n), .lds_n(lds_n), .din(din),
    .dout(dout), .irq(irq)
  );

  kbd_port68 #(.DEPTH(DEPTH), .C_RELEASE_EVENTS(1'b0)) dut_nr (
    .clk(clk), .reset(reset), .ps2_key(ps2_key), .cs(cs), .as_n(as_n),
    .rw(rw), .addr(addr), .uds_n(uds_n), .lds_n(lds_n), .din(din),
    .dout(dout_nr), .irq(irq_nr)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (release events queued) ----------------
  logic [9:0]  mq[$];
  bit          m_ovf, m_irqen, m_irq, m_armed, m_prev;
  bit          m_pend, m_rw, m_addr, m_uds;
  logic [15:0] m_din;
  bit          m_commit, m_swr, m_wasfull;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_ovf = 0; m_irqen = 0; m_irq = 0; m_armed = 0; m_prev = 0; m_pend = 0;
    end else begin
      m_commit = m_pend && as_n;
      m_swr    = m_commit && !m_rw && m_addr && !m_uds;
      if (m_swr) begin
        m_irqen = m_din[8];
        if (m_din[15]) m_ovf = 0;
      end
      if (m_swr && m_din[14]) begin
        mq.delete();
      end else begin
        m_wasfull = (mq.size() == DEPTH);
        if (m_commit && m_rw && !m_addr && mq.size() > 0) void'(mq.pop_front());
        if (m_armed && ps2_key[10] != m_prev) begin
          if (m_wasfull) m_ovf = 1;
          else mq.push_back(ps2_key[9:0]);
        end
      end
      m_irq   = m_irqen && (mq.size() != 0);
      m_prev  = ps2_key[10];
      m_armed = 1;
      if (cs && !as_n) begin
        m_pend = 1; m_rw = rw; m_addr = addr; m_uds = uds_n; m_din = din;
      end else if (m_commit) begin
        m_pend = 0;
      end
    end
  end

  function automatic logic [15:0] model_dout(input logic a);
    if (a == 1'b0)
      return (mq.size() != 0) ? {1'b1, 5'b0, mq[0]} : 16'h0000;
    else
      return {m_ovf, 6'b0, m_irqen, 1'b0, 7'(mq.size())};
  endfunction

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (!reset) begin
      check("dout_vs_model", dout, model_dout(addr));
      check("irq_vs_model", {15'b0, irq}, {15'b0, m_irq});
    end
  end

  // ---------------- stimulus helpers (all start at posedge+2) ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic toggle(input bit p, input bit e, input logic [7:0] code);
    ps2_key = {~ps2_key[10], p, e, code};
    tick();
  endtask

  task automatic access(input bit r, input bit a, input bit u, input logic [15:0] d,
                        input bit tog, input logic [9:0] tkey, output logic [15:0] rd);
    cs = 1; as_n = 0; rw = r; addr = a; uds_n = u; lds_n = 0; din = d;
    tick();
    @(negedge clk);
    rd = dout;
    @(posedge clk);
    #2;
    cs = 0; as_n = 1; uds_n = 1; lds_n = 1;
    if (tog) ps2_key = {~ps2_key[10], tkey};
    tick();
  endtask

  task automatic peek(input bit a, output logic [15:0] v);
    addr = a;
    @(negedge clk);
    v = dout;
    @(posedge clk);
    #2;
  endtask

  logic [15:0] v, v2;

  initial begin
    reset = 1; ps2_key = 11'h400; cs = 0; as_n = 1; rw = 1; addr = 0;
    uds_n = 1; lds_n = 1; din = 16'h0000;
    repeat (3) @(posedge clk);
    #2 reset = 0;

    // Idle with toggle held high: nothing queued
    repeat (10) tick();
    peek(REG_DATA, v);   check("reset_data", v, 16'h0000);
    peek(REG_STATUS, v); check("reset_status", v, 16'h0000);
    check("reset_irq", {15'b0, irq}, 16'h0000);

    // Single pressed event and DATA read
    toggle(1, 0, 8'h1C);
    access(1, REG_DATA, 0, 16'h0, 0, 10'h0, v);
    check("read_1c", v, 16'h821C);
    peek(REG_STATUS, v); check("count_after_pop", v, 16'h0000);

    // irq enable, event raises irq, pop drops it
    access(0, REG_STATUS, 0, 16'h0100, 0, 10'h0, v);
    check("irq_idle_en", {15'b0, irq}, 16'h0000);
    toggle(1, 0, 8'h2A);
    check("irq_rise", {15'b0, irq}, 16'h0001);
    peek(REG_STATUS, v); check("status_irqen_cnt1", v, 16'h0101);
    access(1, REG_DATA, 0, 16'h0, 0, 10'h0, v);
    check("read_2a", v, 16'h822A);
    check("irq_fall", {15'b0, irq}, 16'h0000);

    // Disable irq, overfill by one
    access(0, REG_STATUS, 0, 16'h0000, 0, 10'h0, v);
    for (int i = 1; i <= 17; i++) toggle(1, i[0], 8'(i));
    peek(REG_STATUS, v); check("status_full_ovf", v, 16'h8010);
    for (int i = 1; i <= 16; i++) begin
      access(1, REG_DATA, 0, 16'h0, 0, 10'h0, v);
      check($sformatf("fifo_order_%0d", i), v, {8'h82 | 8'(i[0]), 8'(i)});
    end
    access(1, REG_DATA, 0, 16'h0, 0, 10'h0, v);
    check("read_empty", v, 16'h0000);
    access(0, REG_STATUS, 0, 16'h8000, 0, 10'h0, v);
    peek(REG_STATUS, v); check("ovf_cleared", v, 16'h0000);

    // Push coincident with pop at count 3
    toggle(1, 0, 8'hA0); toggle(1, 0, 8'hA1); toggle(1, 0, 8'hA2);
    access(1, REG_DATA, 0, 16'h0, 1, 10'h2A3, v);
    check("coinc_read_a0", v, 16'h82A0);
    peek(REG_STATUS, v); check("coinc_count3", v, 16'h0003);
    access(1, REG_DATA, 0, 16'h0, 0, 10'h0, v); check("coinc_a1", v, 16'h82A1);
    access(1, REG_DATA, 0, 16'h0, 0, 10'h0, v); check("coinc_a2", v, 16'h82A2);
    access(1, REG_DATA, 0, 16'h0, 0, 10'h0, v); check("coinc_a3", v, 16'h82A3);

    // Overflow-set coincident with overflow-clear: set wins
    for (int i = 0; i < 17; i++) toggle(1, 1, 8'h40 + 8'(i));
    access(0, REG_STATUS, 0, 16'h8000, 1, 10'h377, v);
    peek(REG_STATUS, v); check("ovf_set_wins", v, 16'h8010);
    access(0, REG_STATUS, 0, 16'hC000, 0, 10'h0, v);
    peek(REG_STATUS, v); check("flush_clear", v, 16'h0000);

    // Release event: queued only with C_RELEASE_EVENTS=1
    toggle(0, 0, 8'h55);
    addr = REG_STATUS;
    @(negedge clk);
    v = dout; v2 = dout_nr;
    @(posedge clk); #2;
    check("release_queued", v, 16'h0001);
    check("release_dropped", v2, 16'h0000);
    check("release_irq_nr", {15'b0, irq_nr}, 16'h0000);
    peek(REG_DATA, v); check("release_data", v, 16'h8055);

    // Reset in the middle of a DATA read
    toggle(1, 0, 8'h11);
    cs = 1; as_n = 0; rw = 1; addr = REG_DATA; uds_n = 0; lds_n = 0;
    tick();
    reset = 1;
    tick();
    cs = 0; as_n = 1; uds_n = 1; lds_n = 1;
    tick();
    reset = 0;
    repeat (3) tick();
    peek(REG_STATUS, v); check("midreset_status", v, 16'h0000);
    peek(REG_DATA, v);   check("midreset_data", v, 16'h0000);
    toggle(1, 0, 8'h3C);
    peek(REG_DATA, v);   check("post_reset_event", v, 16'h823C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
